clk_div_prog: RTL and testbench

Multi-channel, runtime-programmable clock divider for the amplifier frontend. It generalises the fixed power-of-two divider: each channel divides `clk_in` by any integer ratio from 2 to 2^W−1. Each channel produces a near-50 % duty divided clock and a one-cycle tick, which serves as a clock enable. Ratio changes take effect only at a period boundary, so downstream logic never sees a runt pulse. The block sits between the system clock and the frontend's sample, PWM and I2S timing logic.

---
 rtl/clk_div_prog.sv | 85 ++++++++
 tb/tb_clk_div_prog.sv | 136 +++++++++++++
 2 files changed

// File: rtl/clk_div_prog.sv
// Multi-channel runtime-programmable clock divider producing a divided clock and period tick per channel.
// Optional macro CLK_DIV_SYNC_EN enables the sync strobe that phase-aligns all channels.
module clk_div_prog #(
  parameter int unsigned CH = 2,
  parameter int unsigned W  = 8
) (
  input  logic              clk_in,
  input  logic              reset,
  input  logic [CH*W-1:0]   div,
  input  logic              sync,
  output logic [CH-1:0]     clk,
  output logic [CH-1:0]     tick
);

  localparam int unsigned WH = W + 1;

`ifndef CLK_DIV_SYNC_EN
  logic unused_sync;
  assign unused_sync = sync;
`endif

  for (genvar c = 0; c < CH; c++) begin : g_ch
    logic [W-1:0]  req;
    logic [W-1:0]  act_q, act_d;
    logic [W-1:0]  cnt_q, cnt_d;
    logic          clk_q, clk_d;
    logic          tick_q, tick_d;
    logic          wrap;
    logic [WH-1:0] h_cur;

    assign req   = div[c*W +: W];
    assign wrap  = (cnt_q == act_q - W'(1));
    assign h_cur = (WH'(act_q) + WH'(1)) >> 1;

    // Next-state: idle sampling, period wrap with ratio reload, or in-period count
    always_comb begin
      act_d  = act_q;
      cnt_d  = cnt_q;
      clk_d  = clk_q;
      tick_d = tick_q;
      if (act_q == '0) begin
        cnt_d  = '0;
        act_d  = req;
        clk_d  = (req != '0);
        tick_d = (req != '0);
      end else if (wrap) begin
        // phase 0 of any nonzero ratio is always in the high half
        act_d  = req;
        cnt_d  = '0;
        clk_d  = (req != '0);
        tick_d = (req != '0);
      end else begin
        cnt_d  = cnt_q + W'(1);
        clk_d  = (WH'(cnt_q + W'(1)) < h_cur);
        tick_d = 1'b0;
      end
`ifdef CLK_DIV_SYNC_EN
      if (sync) begin
        act_d  = req;
        cnt_d  = '0;
        clk_d  = (req != '0);
        tick_d = (req != '0);
      end
`endif
    end

    always_ff @(posedge clk_in or posedge reset) begin
      if (reset) begin
        act_q  <= '0;
        cnt_q  <= '0;
        clk_q  <= 1'b0;
        tick_q <= 1'b0;
      end else begin
        act_q  <= act_d;
        cnt_q  <= cnt_d;
        clk_q  <= clk_d;
        tick_q <= tick_d;
      end
    end

    assign clk[c]  = clk_q;
    assign tick[c] = tick_q;
  end

endmodule

// File: tb/tb_clk_div_prog.sv
// Directed bench for clk_div_prog (CH=2, W=8); expectations follow CLK_DIV_SYNC_EN when defined.
module tb_clk_div_prog;

  localparam int unsigned CH = 2;
  localparam int unsigned W  = 8;

  logic              clk_in;
  logic              reset;
  logic [CH*W-1:0]   div;
  logic              sync;
  logic [CH-1:0]     clk;
  logic [CH-1:0]     tick;

  int tests = 0;
  int fails = 0;

  clk_div_prog #(.CH(CH), .W(W)) dut (
    .clk_in (clk_in),
    .reset  (reset),
    .div    (div),
    .sync   (sync),
    .clk    (clk),
    .tick   (tick)
  );

  initial clk_in = 1'b0;
  always #5 clk_in = ~clk_in;

  task automatic chk(input logic obs, input logic exp, input string tag, input int cyc);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s cyc %0d: observed %b expected %b", tag, cyc, obs, exp);
    end
  endtask

  // Bit i of each vector is the expected value after the i-th upcoming edge
  task automatic run(input int n, input logic [31:0] c0, input logic [31:0] t0,
                     input logic [31:0] c1, input logic [31:0] t1, input string tag);
    for (int i = 0; i < n; i++) begin
      @(posedge clk_in);
      #1;
      chk(clk[0],  c0[i], {tag, "/clk0"},  i);
      chk(tick[0], t0[i], {tag, "/tick0"}, i);
      chk(clk[1],  c1[i], {tag, "/clk1"},  i);
      chk(tick[1], t1[i], {tag, "/tick1"}, i);
    end
  endtask

  task automatic set_div(input logic [W-1:0] d0, input logic [W-1:0] d1);
    div = {d1, d0};
  endtask

  logic [31:0] ec0, et0, ec1, et1;

  initial begin
    reset = 1'b1;
    sync  = 1'b0;
    set_div(8'd0, 8'd0);
    #12;
    chk(clk[0], 1'b0, "rst/clk0", 0);
    chk(clk[1], 1'b0, "rst/clk1", 0);
    chk(tick[0], 1'b0, "rst/tick0", 0);
    chk(tick[1], 1'b0, "rst/tick1", 0);
    @(posedge clk_in);
    #1;
    reset = 1'b0;
    run(2, 32'h0, 32'h0, 32'h0, 32'h0, "idle");

    // Ratio 4: 1100 with tick every 4th edge, starting on the first edge
    set_div(8'd4, 8'd0);
    run(8, 32'h33, 32'h11, 32'h0, 32'h0, "div4");
    // Ratio 5: high 3, low 2
    set_div(8'd5, 8'd0);
    run(10, 32'h0E7, 32'h021, 32'h0, 32'h0, "div5");
    // Ratio 2: toggles every edge
    set_div(8'd2, 8'd0);
    run(6, 32'h15, 32'h15, 32'h0, 32'h0, "div2");
    // Ratio 1: tick and clk stuck high
    set_div(8'd1, 8'd0);
    run(4, 32'hF, 32'hF, 32'h0, 32'h0, "div1");

    // Ratio 6, switch to 3 at cnt=2: rest of the 6-period unchanged
    set_div(8'd6, 8'd0);
    run(3, 32'h7, 32'h1, 32'h0, 32'h0, "div6");
    set_div(8'd3, 8'd0);
    run(9, 32'h0D8, 32'h048, 32'h0, 32'h0, "div6to3");

    // Ratio 4, drop to 0 mid-period: finish period, then hold idle
    set_div(8'd4, 8'd0);
    run(2, 32'h3, 32'h1, 32'h0, 32'h0, "div4b");
    set_div(8'd0, 8'd0);
    run(6, 32'h0, 32'h0, 32'h0, 32'h0, "stop");
    set_div(8'd4, 8'd0);
    run(4, 32'h3, 32'h1, 32'h0, 32'h0, "restart");

    // Asynchronous reset between edges
    run(1, 32'h1, 32'h1, 32'h0, 32'h0, "pre_rst");
    #3;
    reset = 1'b1;
    #1;
    chk(clk[0], 1'b0, "async_rst/clk0", 0);
    chk(tick[0], 1'b0, "async_rst/tick0", 0);
    @(posedge clk_in);
    #1;
    chk(clk[0], 1'b0, "held_rst/clk0", 0);
    chk(tick[0], 1'b0, "held_rst/tick0", 0);
    reset = 1'b0;
    run(4, 32'h3, 32'h1, 32'h0, 32'h0, "rst_restart");

    // Two channels out of phase, then a one-cycle sync pulse
    set_div(8'd0, 8'd0);
    @(posedge clk_in);
    #1;
    reset = 1'b1;
    #2;
    reset = 1'b0;
    set_div(8'd8, 8'd0);
    run(2, 32'h3, 32'h1, 32'h0, 32'h0, "ph_ch0");
    set_div(8'd8, 8'd4);
    run(2, 32'h3, 32'h0, 32'h3, 32'h1, "ph_ch1");
`ifdef CLK_DIV_SYNC_EN
    ec0 = 32'h0F0F; et0 = 32'h0101; ec1 = 32'h3333; et1 = 32'h1111;
`else
    ec0 = 32'hF0F0; et0 = 32'h1010; ec1 = 32'hCCCC; et1 = 32'h4444;
`endif
    sync = 1'b1;
    run(1, ec0, et0, ec1, et1, "sync_edge");
    sync = 1'b0;
    run(15, ec0 >> 1, et0 >> 1, ec1 >> 1, et1 >> 1, "sync_after");

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
